// File: rtl/dvtb_clk_pkg.sv
// Shared types and default parameters for the DV clock monitor slice.
package dvtb_clk_pkg;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    STOP = 2'd3
  } mon_state_e;

  // Default counter width, synchronizer depth and stopped-clock timeout.
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned SYNC_STG_DEF = 2;
  localparam int unsigned TIMEOUT_DEF  = 1024;

endpackage

// File: rtl/dvtb_sync_edge.sv
// Synchronizes an asynchronous level into the reference domain and emits
// registered single-cycle rise/fall pulses, SYNC_STG+1 cycles after the input.
module dvtb_sync_edge
  import dvtb_clk_pkg::*;
#(
  parameter int unsigned SYNC_STG = SYNC_STG_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STG-1:0] r_sync;
  logic [SYNC_STG-1:0] w_sync_in;
  logic                r_last;
  logic                r_rise;
  logic                r_fall;

  // Stage 0 takes the raw input; every later stage takes its predecessor.
  assign w_sync_in[0] = async_i;
  for (genvar gi = 1; gi < SYNC_STG; gi++) begin : g_stage
    assign w_sync_in[gi] = r_sync[gi-1];
  end

  // Synchronizer chain plus edge-detect registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_last <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= w_sync_in;
      r_last <= r_sync[SYNC_STG-1];
      r_rise <= r_sync[SYNC_STG-1] & ~r_last;
      r_fall <= ~r_sync[SYNC_STG-1] & r_last;
    end
  end

  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/dvtb_clock_monitor.sv
// Oversampling clock monitor: measures period and high time of mon_clk_i in
// reference cycles and raises sticky fast/slow/duty/stopped error flags.
module dvtb_clock_monitor
  import dvtb_clk_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned SYNC_STG = SYNC_STG_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mon_clk_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] exp_min_i,
  input  logic [CNT_W-1:0] exp_max_i,
  input  logic             clr_i,
  output logic             meas_vld_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic [31:0]      edge_cnt_o,
  output logic             err_fast_o,
  output logic             err_slow_o,
  output logic             err_stop_o,
  output logic             err_duty_o
);

  localparam int unsigned      IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mon_state_e        r_state;
  mon_state_e        w_state_next;
  logic              w_rise;
  logic              w_fall;
  logic              w_timeout;
  logic              w_in_meas;
  logic              w_do_meas;
  logic              w_cnt_edge;
  logic              w_set_stop;
  logic              w_is_fast;
  logic              w_is_slow;
  logic              w_is_duty;
  logic [CNT_W-1:0]  w_period;
  logic [CNT_W-1:0]  r_per_cnt;
  logic [CNT_W-1:0]  r_high_lat;
  logic              r_fall_seen;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high;
  logic              r_meas_vld;
  logic [31:0]       r_edge_cnt;
  logic              r_err_fast;
  logic              r_err_slow;
  logic              r_err_stop;
  logic              r_err_duty;

  dvtb_sync_edge #(
    .SYNC_STG (SYNC_STG)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (mon_clk_i),
    .rise_o  (w_rise),
    .fall_o  (w_fall)
  );

  // Stopped clock: the cycle in which the edge-free count would reach TIMEOUT.
  assign w_timeout = (r_state == MEAS) && !w_rise && !w_fall &&
                     (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state; dropping en_i always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    if (!en_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = ARM;
        ARM:     if (w_rise)    w_state_next = MEAS;
        MEAS:    if (w_timeout) w_state_next = STOP;
        STOP:    if (w_rise)    w_state_next = ARM;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: strobes that steer the counters and result registers.
  always_comb begin
    w_in_meas  = en_i && (r_state == MEAS);
    w_do_meas  = w_in_meas && w_rise;
    w_cnt_edge = en_i && (r_state != IDLE) && w_rise;
    w_set_stop = w_in_meas && w_timeout;
  end

  // Period in progress (saturating) and the checks applied when it closes.
  always_comb begin
    w_period  = (r_per_cnt == CNT_MAX) ? CNT_MAX : r_per_cnt + CNT_W'(1);
    w_is_fast = w_period < exp_min_i;
    w_is_slow = (w_period > exp_max_i) || (w_period == CNT_MAX);
    w_is_duty = !r_fall_seen || (r_high_lat == '0) || (r_high_lat >= w_period);
  end

  // Period, high-time and edge-free counters; only run while measuring.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_per_cnt   <= '0;
      r_high_lat  <= '0;
      r_fall_seen <= 1'b0;
      r_idle_cnt  <= '0;
    end else if (!w_in_meas || w_rise) begin
      r_per_cnt   <= '0;
      r_high_lat  <= '0;
      r_fall_seen <= 1'b0;
      r_idle_cnt  <= '0;
    end else begin
      if (r_per_cnt != CNT_MAX) r_per_cnt <= r_per_cnt + CNT_W'(1);
      if (w_fall) begin
        r_high_lat  <= w_period;
        r_fall_seen <= 1'b1;
        r_idle_cnt  <= '0;
      end else begin
        r_idle_cnt  <= r_idle_cnt + IDLE_W'(1);
      end
    end
  end

  // Measurement results and the one-cycle valid pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meas_vld <= 1'b0;
      r_period   <= '0;
      r_high     <= '0;
    end else begin
      r_meas_vld <= w_do_meas;
      if (w_do_meas) begin
        r_period <= w_period;
        r_high   <= r_high_lat;
      end
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_fast <= 1'b0;
      r_err_slow <= 1'b0;
      r_err_stop <= 1'b0;
      r_err_duty <= 1'b0;
    end else begin
      r_err_fast <= (w_do_meas && w_is_fast) || (r_err_fast && !clr_i);
      r_err_slow <= (w_do_meas && w_is_slow) || (r_err_slow && !clr_i);
      r_err_duty <= (w_do_meas && w_is_duty) || (r_err_duty && !clr_i);
      r_err_stop <= w_set_stop || (r_err_stop && !clr_i);
    end
  end

  // Rising-edge counter; wraps naturally, cleared by clr_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           r_edge_cnt <= '0;
    else if (clr_i)      r_edge_cnt <= '0;
    else if (w_cnt_edge) r_edge_cnt <= r_edge_cnt + 32'd1;
  end

  assign meas_vld_o = r_meas_vld;
  assign period_o   = r_period;
  assign high_o     = r_high;
  assign edge_cnt_o = r_edge_cnt;
  assign err_fast_o = r_err_fast;
  assign err_slow_o = r_err_slow;
  assign err_stop_o = r_err_stop;
  assign err_duty_o = r_err_duty;

endmodule

// File: tb/tb_dvtb_clock_monitor.sv
// Bench for dvtb_clock_monitor: directed scenarios plus random clock shapes,
// checked every cycle against an event-timestamp reference model.
module tb_dvtb_clock_monitor;

  localparam int CNT_W    = 16;
  localparam int SYNC_STG = 2;
  localparam int TIMEOUT  = 1024;
  localparam int LAG      = SYNC_STG + 1;
  localparam int PMAX     = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2, M_STOP = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             mon;
  logic             en;
  logic             clr;
  logic [CNT_W-1:0] exp_min;
  logic [CNT_W-1:0] exp_max;
  logic             meas_vld_o;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic [31:0]      edge_cnt_o;
  logic             err_fast_o, err_slow_o, err_stop_o, err_duty_o;

  int n_vec = 0;
  int n_err = 0;

  dvtb_clock_monitor #(
    .CNT_W    (CNT_W),
    .SYNC_STG (SYNC_STG),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mon_clk_i  (mon),
    .en_i       (en),
    .exp_min_i  (exp_min),
    .exp_max_i  (exp_max),
    .clr_i      (clr),
    .meas_vld_o (meas_vld_o),
    .period_o   (period_o),
    .high_o     (high_o),
    .edge_cnt_o (edge_cnt_o),
    .err_fast_o (err_fast_o),
    .err_slow_o (err_slow_o),
    .err_stop_o (err_stop_o),
    .err_duty_o (err_duty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: works on timestamps of synchronized mon edges.
  bit          hist [0:LAG+1];
  int          m_mode = M_IDLE;
  int          n_cyc = 0, t_rise = 0, t_fall = -1, t_edge = 0;
  bit          e_vld = 0, e_fast = 0, e_slow = 0, e_stop = 0, e_duty = 0;
  int          e_per = 0, e_high = 0;
  logic [31:0] e_ecnt = '0;

  always @(posedge clk) begin : model
    bit rise, fall, s_f, s_s, s_st, s_d, inc;
    int per, hi;
    if (rst) begin
      foreach (hist[i]) hist[i] = 1'b0;
      m_mode = M_IDLE; n_cyc = 0; t_rise = 0; t_fall = -1; t_edge = 0;
      e_vld = 0; e_fast = 0; e_slow = 0; e_stop = 0; e_duty = 0;
      e_per = 0; e_high = 0; e_ecnt = '0;
    end else begin
      n_cyc++;
      for (int i = LAG + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = mon;
      rise = hist[LAG] && !hist[LAG+1];
      fall = !hist[LAG] && hist[LAG+1];
      e_vld = 0; s_f = 0; s_s = 0; s_st = 0; s_d = 0; inc = 0;
      if (!en) m_mode = M_IDLE;
      else if (m_mode == M_IDLE) m_mode = M_ARM;
      else if (m_mode == M_ARM) begin
        if (rise) begin
          m_mode = M_MEAS; t_rise = n_cyc; t_fall = -1; t_edge = n_cyc; inc = 1;
        end
      end else if (m_mode == M_MEAS) begin
        if (rise) begin
          per = n_cyc - t_rise;
          if (per > PMAX) per = PMAX;
          hi = (t_fall < 0) ? 0 : t_fall - t_rise;
          e_vld = 1; e_per = per; e_high = hi;
          s_f = per < int'(exp_min);
          s_s = (per > int'(exp_max)) || (per == PMAX);
          s_d = (t_fall < 0) || (hi == 0) || (hi >= per);
          t_rise = n_cyc; t_fall = -1; t_edge = n_cyc; inc = 1;
        end else if (fall) begin
          t_fall = n_cyc; t_edge = n_cyc;
        end else if (n_cyc - t_edge >= TIMEOUT) begin
          m_mode = M_STOP; s_st = 1;
        end
      end else begin
        if (rise) begin m_mode = M_ARM; inc = 1; end
      end
      e_fast = s_f  || (e_fast && !clr);
      e_slow = s_s  || (e_slow && !clr);
      e_duty = s_d  || (e_duty && !clr);
      e_stop = s_st || (e_stop && !clr);
      e_ecnt = clr ? 32'd0 : e_ecnt + 32'(inc);
    end
  end

  // Every-cycle compare, on the inactive clock edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("vld_rst", meas_vld_o, 0);
      chk("ecnt_rst", edge_cnt_o, 0);
      chk("errs_rst", {err_fast_o, err_slow_o, err_stop_o, err_duty_o}, 0);
    end else begin
      chk("meas_vld", meas_vld_o, e_vld);
      chk("period", period_o, e_per);
      chk("high", high_o, e_high);
      chk("edge_cnt", edge_cnt_o, e_ecnt);
      chk("err_fast", err_fast_o, e_fast);
      chk("err_slow", err_slow_o, e_slow);
      chk("err_stop", err_stop_o, e_stop);
      chk("err_duty", err_duty_o, e_duty);
    end
  end

  task automatic run_clk(input int per, input int hi, input int nper, input bit rnd);
    for (int i = 0; i < per * nper; i++) begin
      @(negedge clk);
      mon = ((i % per) < hi);
      if (rnd) begin
        clr = ($urandom_range(0, 59) == 0);
        en  = ($urandom_range(0, 149) != 0);
      end
    end
    en  = 1'b1;
    clr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, meas_vld_o, 0);
    chk({tag, "_period"}, period_o, 0);
    chk({tag, "_high"}, high_o, 0);
    chk({tag, "_ecnt"}, edge_cnt_o, 0);
    chk({tag, "_fast"}, err_fast_o, 0);
    chk({tag, "_slow"}, err_slow_o, 0);
    chk({tag, "_stop"}, err_stop_o, 0);
    chk({tag, "_duty"}, err_duty_o, 0);
  endtask

  initial begin
    int first_vld;
    rst = 1'b1; mon = 1'b0; en = 1'b0; clr = 1'b0;
    exp_min = 16'd15; exp_max = 16'd17;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0; en = 1'b1;

    // Nominal 16-cycle clock, 50% duty.
    run_clk(16, 8, 10, 0);
    @(negedge clk);
    chk("nom_period", period_o, 16);
    chk("nom_high", high_o, 8);
    chk("nom_ecnt", edge_cnt_o, 10);
    chk("nom_errs", {err_fast_o, err_slow_o, err_stop_o, err_duty_o}, 0);

    // Faster clock trips err_fast; clear and re-trip, then recover.
    run_clk(10, 5, 4, 0);
    @(negedge clk);
    chk("fast_set", err_fast_o, 1);
    pulse_clr();
    run_clk(10, 5, 3, 0);
    run_clk(16, 8, 3, 0);
    pulse_clr();
    run_clk(16, 8, 3, 0);
    @(negedge clk);
    chk("fast_recovered", err_fast_o, 0);

    // Stopped clock, then restart.
    run_clk(1100, 0, 1, 0);
    @(negedge clk);
    chk("stop_set", err_stop_o, 1);
    pulse_clr();
    run_clk(16, 8, 6, 0);
    @(negedge clk);
    chk("restart_errs", {err_fast_o, err_slow_o, err_stop_o, err_duty_o}, 0);
    chk("restart_period", period_o, 16);

    // One-cycle glitch high in a low phase.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      mon = ((i % 16) < 8) || (i == 28);
    end
    @(negedge clk);
    chk("glitch_fast", err_fast_o, 1);
    pulse_clr();

    // Enable dropped mid-period, re-raised at a period start.
    run_clk(16, 8, 2, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mon = (i < 8);
      en  = (i < 5);
    end
    first_vld = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (meas_vld_o && first_vld < 0) first_vld = c;
      mon = ((c % 16) < 8);
      en  = 1'b1;
    end
    chk("reenable_first_vld", first_vld, 20);

    // Random clock shapes, limits, clears and enable drops.
    for (int s = 0; s < 40; s++) begin
      exp_min = 16'($urandom_range(3, 40));
      exp_max = 16'($urandom_range(3, 40));
      if ($urandom_range(0, 9) == 0) run_clk($urandom_range(1000, 1100), 0, 1, 0);
      begin
        int per;
        per = $urandom_range(4, 40);
        run_clk(per, $urandom_range(0, per), $urandom_range(1, 4), 1);
      end
    end
    exp_min = 16'd15; exp_max = 16'd17;

    // Asynchronous reset in the middle of a measurement.
    run_clk(16, 8, 3, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_clk(16, 8, 3, 0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
